// File: rtl/flash_read_arbiter_if.sv
// Request/response bundle for the two flash readers plus the SPI pins of flash_read_arbiter.
// The arbiter takes the slave modport; requesters and the flash model sit on the master side.
interface flash_read_arbiter_if;
    logic        a_valid;
    logic [23:0] a_address;
    logic        a_ready;
    logic [7:0]  a_data;
    logic        b_valid;
    logic [23:0] b_address;
    logic        b_ready;
    logic [7:0]  b_data;
    logic        spi_cs_n;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;
    logic        busy;

    modport slave (
        input  a_valid, a_address, b_valid, b_address, spi_miso,
        output a_ready, a_data, b_ready, b_data, spi_cs_n, spi_sck, spi_mosi, busy
    );

    modport master (
        output a_valid, a_address, b_valid, b_address, spi_miso,
        input  a_ready, a_data, b_ready, b_data, spi_cs_n, spi_sck, spi_mosi, busy
    );
endinterface

// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter sharing one SPI NOR flash between two byte readers.
// Each grant runs a single READ transaction: 8-bit command, 24-bit address, 8-bit data.
module flash_read_arbiter #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned CS_GAP   = 4,
    parameter logic [7:0]  CMD_READ = 8'h03
) (
    input logic                  clk,
    input logic                  rst,
    flash_read_arbiter_if.slave  bus
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GapW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [DivW-1:0] DivLast   = DivW'(CLK_DIV - 1);
    localparam logic [GapW-1:0] GapLast   = GapW'(CS_GAP - 1);
    localparam logic [5:0]      FirstData = 6'd32;
    localparam logic [5:0]      LastBit   = 6'd39;

    typedef enum logic [1:0] {StIdle, StShift, StDone, StGap} state_e;

    state_e          state_q, state_d;
    logic [31:0]     shreg_q, shreg_d;
    logic [7:0]      rx_q, rx_d;
    logic [5:0]      bit_q, bit_d;
    logic [DivW-1:0] div_q, div_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic            grant_b_q, grant_b_d;
    logic            last_b_q, last_b_d;
    logic            sck_q, sck_d, cs_n_q, cs_n_d, mosi_q, mosi_d, busy_q, busy_d;
    logic            a_ready_q, a_ready_d, b_ready_q, b_ready_d;
    logic [7:0]      a_data_q, a_data_d, b_data_q, b_data_d;

    logic        pick_b;
    logic [23:0] grant_addr;

    // With both requesting, B wins only if A was served last.
    assign pick_b     = bus.b_valid && (!bus.a_valid || !last_b_q);
    assign grant_addr = pick_b ? bus.b_address : bus.a_address;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        rx_d      = rx_q;
        bit_d     = bit_q;
        div_d     = div_q;
        gap_d     = gap_q;
        grant_b_d = grant_b_q;
        last_b_d  = last_b_q;
        sck_d     = sck_q;
        cs_n_d    = cs_n_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        a_ready_d = 1'b0;
        b_ready_d = 1'b0;
        a_data_d  = a_data_q;
        b_data_d  = b_data_q;

        unique case (state_q)
            StIdle: begin
                if (bus.a_valid || bus.b_valid) begin
                    grant_b_d = pick_b;
                    last_b_d  = pick_b;
                    // MSB of the command goes straight to MOSI; zeros refill the tail so
                    // the 8 data-phase bits drive MOSI low without extra logic.
                    mosi_d    = CMD_READ[7];
                    shreg_d   = {CMD_READ[6:0], grant_addr, 1'b0};
                    rx_d      = 8'h00;
                    bit_d     = 6'd0;
                    div_d     = '0;
                    sck_d     = 1'b0;
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (div_q == DivLast) begin
                    div_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        if (bit_q >= FirstData) rx_d = {rx_q[6:0], bus.spi_miso};
                    end else if (bit_q == LastBit) begin
                        sck_d   = 1'b0;
                        cs_n_d  = 1'b1;
                        mosi_d  = 1'b0;
                        state_d = StDone;
                        if (grant_b_q) begin
                            b_ready_d = 1'b1;
                            b_data_d  = rx_q;
                        end else begin
                            a_ready_d = 1'b1;
                            a_data_d  = rx_q;
                        end
                    end else begin
                        sck_d   = 1'b0;
                        bit_d   = bit_q + 6'd1;
                        mosi_d  = shreg_q[31];
                        shreg_d = {shreg_q[30:0], 1'b0};
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StDone: begin
                gap_d   = '0;
                state_d = StGap;
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            rx_q      <= '0;
            bit_q     <= '0;
            div_q     <= '0;
            gap_q     <= '0;
            grant_b_q <= 1'b0;
            last_b_q  <= 1'b1;
            sck_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            a_ready_q <= 1'b0;
            b_ready_q <= 1'b0;
            a_data_q  <= '0;
            b_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            rx_q      <= rx_d;
            bit_q     <= bit_d;
            div_q     <= div_d;
            gap_q     <= gap_d;
            grant_b_q <= grant_b_d;
            last_b_q  <= last_b_d;
            sck_q     <= sck_d;
            cs_n_q    <= cs_n_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            a_ready_q <= a_ready_d;
            b_ready_q <= b_ready_d;
            a_data_q  <= a_data_d;
            b_data_q  <= b_data_d;
        end
    end

    assign bus.spi_cs_n = cs_n_q;
    assign bus.spi_sck  = sck_q;
    assign bus.spi_mosi = mosi_q;
    assign bus.busy     = busy_q;
    assign bus.a_ready  = a_ready_q;
    assign bus.a_data   = a_data_q;
    assign bus.b_ready  = b_ready_q;
    assign bus.b_data   = b_data_q;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Bench for flash_read_arbiter: three instances (CLK_DIV 1/2/3) each with a flash model and
// mode-0 monitor; scenario tasks check grants, data, frames and timing against a reference model.
module tb_flash_read_arbiter;

    localparam int unsigned CsGap = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   last_was_b = 1'b1;  // reference round-robin state: "B last" means A goes first

    always #5 clk = ~clk;

    flash_read_arbiter_if bus[3] ();

    // Flash contents: 0x012345 reads back 0xA5.
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hC2;
    endfunction

    function automatic logic flash_bit(input logic [23:0] a, input int i);
        logic [7:0] b;
        b = flash_byte(a);
        return b[i];
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        flash_read_arbiter #(.CLK_DIV(g + 1), .CS_GAP(CsGap), .CMD_READ(8'h03)) u_dut (
            .clk(clk), .rst(rst), .bus(bus[g]));

        logic [39:0] cap = '0;
        logic [39:0] last_frame = '0;
        logic [7:0]  rbyte = '0;
        int          nbits = 0;
        int          last_bits = 0;
        int          viol = 0;
        logic        prev_sck = 1'b0, prev_mosi = 1'b0, prev_cs = 1'b1;

        // Flash model and mode-0 protocol monitor, sampled away from the active edge.
        always @(negedge clk) begin
            if ((bus[g].spi_cs_n && bus[g].spi_sck) ||
                (!prev_sck && bus[g].spi_sck && bus[g].spi_mosi !== prev_mosi) ||
                (bus[g].a_ready && bus[g].b_ready))
                viol <= viol + 1;
            if (bus[g].spi_cs_n) begin
                if (!prev_cs) begin
                    last_frame <= cap;
                    last_bits  <= nbits;
                end
                nbits           <= 0;
                bus[g].spi_miso <= 1'b0;
            end else if (!prev_sck && bus[g].spi_sck) begin
                cap   <= {cap[38:0], bus[g].spi_mosi};
                nbits <= nbits + 1;
            end else if (prev_sck && !bus[g].spi_sck) begin
                if (nbits == 32) begin
                    rbyte           <= flash_byte(cap[23:0]);
                    bus[g].spi_miso <= flash_bit(cap[23:0], 7);
                end else if (nbits > 32 && nbits < 40) begin
                    bus[g].spi_miso <= rbyte[3'(39 - nbits)];
                end
            end
            prev_sck  <= bus[g].spi_sck;
            prev_mosi <= bus[g].spi_mosi;
            prev_cs   <= bus[g].spi_cs_n;
        end
    end

    // Waits for the next transaction on instance 1 and returns its outcome (no checking here).
    task automatic run_txn(input bit drop_at_grant, output logic gb, output logic [7:0] d,
                           output int lat, output int gap, output bit to);
        to = 1'b0; gb = 1'b0; d = '0; lat = 0; gap = 0;
        while (bus[1].spi_cs_n === 1'b1 && gap < 2000) begin
            gap++;
            @(negedge clk);
        end
        if (gap >= 2000) begin
            to = 1'b1;
            return;
        end
        if (drop_at_grant) begin
            bus[1].a_valid = 1'b0;
            bus[1].b_valid = 1'b0;
        end
        while (!(bus[1].a_ready || bus[1].b_ready) && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 2000) to = 1'b1;
        gb = bus[1].b_ready;
        d  = gb ? bus[1].b_data : bus[1].a_data;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus[1].busy !== 1'b0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k >= 2000) begin
            n_fail++;
            $display("FAIL idle_timeout: busy still %b, want 0", bus[1].busy);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        n_cmp++; if (bus[1].spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL rst_cs_n: got %b want 1", bus[1].spi_cs_n); end
        n_cmp++; if (bus[1].spi_sck !== 1'b0) begin n_fail++; $display("FAIL rst_sck: got %b want 0", bus[1].spi_sck); end
        n_cmp++; if (bus[1].spi_mosi !== 1'b0) begin n_fail++; $display("FAIL rst_mosi: got %b want 0", bus[1].spi_mosi); end
        n_cmp++; if (bus[1].busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus[1].busy); end
        n_cmp++; if ({bus[1].a_ready, bus[1].b_ready} !== 2'b00) begin n_fail++; $display("FAIL rst_ready: got %b want 00", {bus[1].a_ready, bus[1].b_ready}); end
        n_cmp++; if ({bus[1].a_data, bus[1].b_data} !== 16'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0000", {bus[1].a_data, bus[1].b_data}); end
        @(negedge clk);
        rst = 1'b0;
        last_was_b = 1'b1;
        for (int i = 0; i < 5; i++) @(negedge clk);
        n_cmp++; if ({bus[1].busy, bus[1].spi_cs_n} !== 2'b01) begin n_fail++; $display("FAIL idle_no_req: busy,cs_n got %b want 01", {bus[1].busy, bus[1].spi_cs_n}); end
    endtask

    task automatic test_single_read();
        logic gb; logic [7:0] d; int lat, gap; bit to;
        bus[1].a_valid   = 1'b1;
        bus[1].a_address = 24'h012345;
        run_txn(1'b1, gb, d, lat, gap, to);
        last_was_b = 1'b0;
        n_cmp++; if (to || gb !== 1'b0) begin n_fail++; $display("FAIL single_grant: got b=%b to=%b want A", gb, to); end
        n_cmp++; if (d !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", d); end
        // lat counts clk edges after the grant edge: 80 SCK half-periods of 2 clocks.
        n_cmp++; if (lat !== 160) begin n_fail++; $display("FAIL single_latency: got %0d want 160", lat); end
        n_cmp++; if (bus[1].b_data !== 8'h00) begin n_fail++; $display("FAIL single_b_untouched: got %h want 00", bus[1].b_data); end
        @(negedge clk);
        n_cmp++; if (bus[1].a_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_width: got %b want 0", bus[1].a_ready); end
        n_cmp++; if (g_dut[1].last_frame !== {8'h03, 24'h012345, 8'h00}) begin n_fail++; $display("FAIL single_mosi: got %h want 0301234500", g_dut[1].last_frame); end
        n_cmp++; if (g_dut[1].last_bits !== 40) begin n_fail++; $display("FAIL single_bits: got %0d want 40", g_dut[1].last_bits); end
        wait_idle();
    endtask

    task automatic test_both_valid();
        logic gb; logic [7:0] d; int lat, gap; bit to;
        logic [23:0] aa, ba;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        last_was_b = 1'b1;
        aa = 24'($urandom); ba = 24'($urandom);
        bus[1].a_valid = 1'b1; bus[1].a_address = aa;
        bus[1].b_valid = 1'b1; bus[1].b_address = ba;
        run_txn(1'b0, gb, d, lat, gap, to);
        bus[1].a_valid = 1'b0;
        n_cmp++; if (to || gb !== 1'b0) begin n_fail++; $display("FAIL both_first: got b=%b to=%b want A", gb, to); end
        n_cmp++; if (d !== flash_byte(aa)) begin n_fail++; $display("FAIL both_a_data: got %h want %h", d, flash_byte(aa)); end
        run_txn(1'b1, gb, d, lat, gap, to);
        last_was_b = 1'b1;
        n_cmp++; if (to || gb !== 1'b1) begin n_fail++; $display("FAIL both_second: got b=%b to=%b want B", gb, to); end
        n_cmp++; if (d !== flash_byte(ba)) begin n_fail++; $display("FAIL both_b_data: got %h want %h", d, flash_byte(ba)); end
        n_cmp++; if (gap < CsGap) begin n_fail++; $display("FAIL both_gap: got %0d want >= %0d", gap, CsGap); end
    endtask

    task automatic test_back_to_back();
        logic gb; logic [7:0] d; int lat, gap; bit to;
        bit exp_b;
        bus[1].a_valid = 1'b1; bus[1].a_address = 24'($urandom);
        bus[1].b_valid = 1'b1; bus[1].b_address = 24'($urandom);
        for (int i = 0; i < 4; i++) begin
            exp_b = !last_was_b;
            run_txn(1'b0, gb, d, lat, gap, to);
            last_was_b = exp_b;
            n_cmp++; if (to || gb !== exp_b) begin n_fail++; $display("FAIL b2b_grant%0d: got b=%b to=%b want b=%b", i, gb, to, exp_b); end
            n_cmp++; if (d !== flash_byte(exp_b ? bus[1].b_address : bus[1].a_address)) begin n_fail++; $display("FAIL b2b_data%0d: got %h", i, d); end
            n_cmp++; if (gap < CsGap) begin n_fail++; $display("FAIL b2b_gap%0d: got %0d want >= %0d", i, gap, CsGap); end
        end
        bus[1].a_valid = 1'b0; bus[1].b_valid = 1'b0;
        wait_idle();
    endtask

    task automatic test_b_valid_dropped();
        logic [23:0] ba;
        logic [7:0]  a_hold;
        int k = 0;
        bit saw_a = 1'b0;
        a_hold = bus[1].a_data;
        ba = 24'($urandom);
        bus[1].b_valid = 1'b1; bus[1].b_address = ba;
        while (g_dut[1].nbits != 12 && k < 1000) begin @(negedge clk); k++; end
        bus[1].b_valid = 1'b0; bus[1].b_address = ~ba;
        k = 0;
        while (!bus[1].b_ready && k < 1000) begin
            saw_a |= bus[1].a_ready;
            @(negedge clk); k++;
        end
        last_was_b = 1'b1;
        n_cmp++; if (k >= 1000) begin n_fail++; $display("FAIL drop_ready: b_ready got 0 want pulse"); end
        n_cmp++; if (bus[1].b_data !== flash_byte(ba)) begin n_fail++; $display("FAIL drop_data: got %h want %h", bus[1].b_data, flash_byte(ba)); end
        n_cmp++; if (saw_a || bus[1].a_data !== a_hold) begin n_fail++; $display("FAIL drop_a_untouched: a_data %h want %h", bus[1].a_data, a_hold); end
        @(negedge clk);
        n_cmp++; if (g_dut[1].last_frame[31:8] !== ba) begin n_fail++; $display("FAIL drop_addr: got %h want %h", g_dut[1].last_frame[31:8], ba); end
        wait_idle();
    endtask

    task automatic test_reset_mid_read();
        logic gb; logic [7:0] d; int lat, gap; bit to;
        logic [23:0] aa;
        int k = 0;
        bit saw_ready = 1'b0;
        bus[1].a_valid = 1'b1; bus[1].a_address = 24'($urandom);
        while (g_dut[1].nbits != 20 && k < 1000) begin @(negedge clk); k++; end
        bus[1].a_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++; if ({bus[1].spi_cs_n, bus[1].spi_sck} !== 2'b10) begin n_fail++; $display("FAIL midrst_pins: cs_n,sck got %b want 10", {bus[1].spi_cs_n, bus[1].spi_sck}); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            saw_ready |= bus[1].a_ready | bus[1].b_ready;
        end
        rst = 1'b0;
        last_was_b = 1'b1;
        n_cmp++; if (saw_ready || bus[1].a_data !== 8'h00) begin n_fail++; $display("FAIL midrst_no_ready: ready=%b a_data=%h want 0/00", saw_ready, bus[1].a_data); end
        @(negedge clk);
        aa = 24'($urandom);
        bus[1].a_valid = 1'b1; bus[1].a_address = aa;
        run_txn(1'b1, gb, d, lat, gap, to);
        last_was_b = 1'b0;
        n_cmp++; if (to || gb !== 1'b0 || d !== flash_byte(aa)) begin n_fail++; $display("FAIL midrst_reread: got b=%b d=%h want A %h", gb, d, flash_byte(aa)); end
        n_cmp++; if (lat !== 160) begin n_fail++; $display("FAIL midrst_latency: got %0d want 160", lat); end
        wait_idle();
    endtask

    task automatic test_random();
        logic gb; logic [7:0] d; int lat, gap; bit to;
        bit av, bv, exp_b;
        logic [23:0] aa, ba, exp_addr;
        for (int i = 0; i < 10; i++) begin
            av = 1'($urandom); bv = 1'($urandom);
            if (!av && !bv) av = 1'b1;
            aa = 24'($urandom); ba = 24'($urandom);
            if (av && bv) exp_b = !last_was_b;
            else          exp_b = bv;
            exp_addr = exp_b ? ba : aa;
            bus[1].a_valid = av; bus[1].a_address = aa;
            bus[1].b_valid = bv; bus[1].b_address = ba;
            run_txn(1'b1, gb, d, lat, gap, to);
            last_was_b = exp_b;
            n_cmp++; if (to || gb !== exp_b) begin n_fail++; $display("FAIL rand_grant%0d: got b=%b to=%b want b=%b", i, gb, to, exp_b); end
            n_cmp++; if (d !== flash_byte(exp_addr)) begin n_fail++; $display("FAIL rand_data%0d: got %h want %h", i, d, flash_byte(exp_addr)); end
            @(negedge clk);
            n_cmp++; if (g_dut[1].last_frame !== {8'h03, exp_addr, 8'h00}) begin n_fail++; $display("FAIL rand_frame%0d: got %h want 03%h00", i, g_dut[1].last_frame, exp_addr); end
            wait_idle();
        end
    endtask

    task automatic test_clk_div_variants();
        logic [23:0] a0, a2;
        int lat0 = -1, lat2 = -1;
        a0 = 24'($urandom); a2 = 24'($urandom);
        bus[0].a_valid = 1'b1; bus[0].a_address = a0;
        bus[2].a_valid = 1'b1; bus[2].a_address = a2;
        @(negedge clk);
        bus[0].a_valid = 1'b0; bus[2].a_valid = 1'b0;
        for (int k = 1; k < 400 && lat2 < 0; k++) begin
            @(negedge clk);
            if (bus[0].a_ready && lat0 < 0) lat0 = k;
            if (bus[2].a_ready && lat2 < 0) lat2 = k;
        end
        @(negedge clk);
        n_cmp++; if (lat0 !== 80) begin n_fail++; $display("FAIL div1_latency: got %0d want 80", lat0); end
        n_cmp++; if (lat2 !== 240) begin n_fail++; $display("FAIL div3_latency: got %0d want 240", lat2); end
        n_cmp++; if (bus[0].a_data !== flash_byte(a0)) begin n_fail++; $display("FAIL div1_data: got %h want %h", bus[0].a_data, flash_byte(a0)); end
        n_cmp++; if (bus[2].a_data !== flash_byte(a2)) begin n_fail++; $display("FAIL div3_data: got %h want %h", bus[2].a_data, flash_byte(a2)); end
        n_cmp++; if (g_dut[0].last_frame !== {8'h03, a0, 8'h00}) begin n_fail++; $display("FAIL div1_frame: got %h want 03%h00", g_dut[0].last_frame, a0); end
        n_cmp++; if (g_dut[2].last_frame !== {8'h03, a2, 8'h00}) begin n_fail++; $display("FAIL div3_frame: got %h want 03%h00", g_dut[2].last_frame, a2); end
    endtask

    task automatic test_mode0();
        n_cmp++; if (g_dut[0].viol !== 0) begin n_fail++; $display("FAIL mode0_div1: got %0d violations want 0", g_dut[0].viol); end
        n_cmp++; if (g_dut[1].viol !== 0) begin n_fail++; $display("FAIL mode0_div2: got %0d violations want 0", g_dut[1].viol); end
        n_cmp++; if (g_dut[2].viol !== 0) begin n_fail++; $display("FAIL mode0_div3: got %0d violations want 0", g_dut[2].viol); end
    endtask

    initial begin
        bus[0].a_valid = 1'b0; bus[0].b_valid = 1'b0; bus[0].a_address = '0; bus[0].b_address = '0;
        bus[1].a_valid = 1'b0; bus[1].b_valid = 1'b0; bus[1].a_address = '0; bus[1].b_address = '0;
        bus[2].a_valid = 1'b0; bus[2].b_valid = 1'b0; bus[2].a_address = '0; bus[2].b_address = '0;
        test_reset();
        test_single_read();
        test_both_valid();
        test_back_to_back();
        test_b_valid_dropped();
        test_reset_mid_read();
        test_random();
        test_clk_div_variants();
        test_mode0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
